// File: rtl/port_fifo_peripheral_pkg.sv
// Shared constants for the port FIFO peripheral: register offsets and STATUS bit layout.
package port_fifo_peripheral_pkg;

    localparam logic [3:0] OFF_DATA   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_TXLVL  = 4'd2;
    localparam logic [3:0] OFF_RXLVL  = 4'd3;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_TX_OVERFLOW  = 4;
    localparam int ST_RX_UNDERFLOW = 5;

endpackage

// File: rtl/port_fifo.sv
// Synchronous single-clock FIFO; push while full and pop while empty are ignored.
module port_fifo #(
    parameter int BITS       = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BITS-1:0]       din,
    output logic [BITS-1:0]       dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [BITS-1:0]       mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == '0);
    assign level     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage write; contents need no reset because count_r governs validity.
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/port_fifo_peripheral.sv
// CPU port-bus responder with a 16-word window hosting a TX FIFO (CPU to stream)
// and an RX FIFO (stream to CPU), plus sticky error flags and a level interrupt.
module port_fifo_peripheral
    import port_fifo_peripheral_pkg::*;
#(
    parameter int                    BITS         = 16,
    parameter int                    ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDRESS = 16'h1000,
    parameter int                    DEPTH_LOG2   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] port_address,
    input  logic [BITS-1:0]         port_data,
    input  logic                    port_rd,
    input  logic                    port_wr,
    output logic [BITS-1:0]         port_data_out,
    output logic                    port_data_valid,
    output logic [BITS-1:0]         tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [BITS-1:0]         rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    irq
);

    logic                  hit_s, wr_s, rd_s;
    logic [3:0]            offset_s;
    logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [DEPTH_LOG2:0]   tx_level_s, rx_level_s;
    logic [BITS-1:0]       rx_head_s;
    logic                  tx_push_s, rx_pop_s;
    logic                  tx_overflow_r, rx_underflow_r;
    logic [BITS-1:0]       rd_mux_s;
    logic [BITS-1:0]       data_out_r;
    logic                  data_valid_r;

    assign hit_s    = (port_address[ADDRESS_BITS-1:4] == BASE_ADDRESS[ADDRESS_BITS-1:4]);
    assign offset_s = port_address[3:0];
    assign wr_s     = hit_s & port_wr;
    // A simultaneous write takes precedence and suppresses the read entirely.
    assign rd_s     = hit_s & port_rd & ~port_wr;

    assign tx_push_s = wr_s & (offset_s == OFF_DATA);
    assign rx_pop_s  = rd_s & (offset_s == OFF_DATA);

    port_fifo #(.BITS(BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (tx_push_s),
        .pop   (tx_ready),
        .din   (port_data),
        .dout  (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .level (tx_level_s)
    );

    port_fifo #(.BITS(BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (rx_valid),
        .pop   (rx_pop_s),
        .din   (rx_data),
        .dout  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .level (rx_level_s)
    );

    assign tx_valid = ~tx_empty_s;
    assign rx_ready = ~rx_full_s;
    assign irq      = ~rx_empty_s | tx_overflow_r | rx_underflow_r;

    // Read-data mux over the register window.
    always_comb begin
        rd_mux_s = '0;
        case (offset_s)
            OFF_DATA: begin
                if (rx_empty_s) begin
                    rd_mux_s = '0;
                end else begin
                    rd_mux_s = rx_head_s;
                end
            end
            OFF_STATUS: begin
                rd_mux_s[ST_TX_FULL]      = tx_full_s;
                rd_mux_s[ST_TX_EMPTY]     = tx_empty_s;
                rd_mux_s[ST_RX_FULL]      = rx_full_s;
                rd_mux_s[ST_RX_EMPTY]     = rx_empty_s;
                rd_mux_s[ST_TX_OVERFLOW]  = tx_overflow_r;
                rd_mux_s[ST_RX_UNDERFLOW] = rx_underflow_r;
            end
            OFF_TXLVL: rd_mux_s = {{(BITS-DEPTH_LOG2-1){1'b0}}, tx_level_s};
            OFF_RXLVL: rd_mux_s = {{(BITS-DEPTH_LOG2-1){1'b0}}, rx_level_s};
            default:   rd_mux_s = '0;
        endcase
    end

    // Sticky error flags: set on the faulting access, cleared by writing 1 to STATUS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_overflow_r  <= 1'b0;
            rx_underflow_r <= 1'b0;
        end else begin
            if (tx_push_s && tx_full_s) begin
                tx_overflow_r <= 1'b1;
            end else if (wr_s && (offset_s == OFF_STATUS) && port_data[ST_TX_OVERFLOW]) begin
                tx_overflow_r <= 1'b0;
            end else begin
                tx_overflow_r <= tx_overflow_r;
            end
            if (rx_pop_s && rx_empty_s) begin
                rx_underflow_r <= 1'b1;
            end else if (wr_s && (offset_s == OFF_STATUS) && port_data[ST_RX_UNDERFLOW]) begin
                rx_underflow_r <= 1'b0;
            end else begin
                rx_underflow_r <= rx_underflow_r;
            end
        end
    end

    // Registered read return; data holds until the next accepted read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= rd_s;
            if (rd_s) begin
                data_out_r <= rd_mux_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign port_data_out   = data_out_r;
    assign port_data_valid = data_valid_r;

endmodule

// File: tb/tb_port_fifo_peripheral.sv
// Directed self-checking bench for port_fifo_peripheral.
module tb_port_fifo_peripheral;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] port_address;
    logic [15:0] port_data;
    logic        port_rd;
    logic        port_wr;
    logic [15:0] port_data_out;
    logic        port_data_valid;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int total = 0;
    int bad   = 0;

    port_fifo_peripheral dut (
        .CLK             (CLK),
        .RST             (RST),
        .port_address    (port_address),
        .port_data       (port_data),
        .port_rd         (port_rd),
        .port_wr         (port_wr),
        .port_data_out   (port_data_out),
        .port_data_valid (port_data_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .irq             (irq)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        port_address = addr;
        port_data    = data;
        port_wr      = 1'b1;
        cyc();
        port_wr      = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data, output logic valid);
        port_address = addr;
        port_rd      = 1'b1;
        cyc();
        port_rd      = 1'b0;
        data  = port_data_out;
        valid = port_data_valid;
    endtask

    task automatic rx_push(input logic [15:0] data);
        rx_data  = data;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
        total++;
        if ({port_data_out, port_data_valid, tx_valid, rx_ready, irq} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h valid=%b txv=%b rxr=%b irq=%b, want 0000 0 0 1 0",
                     port_data_out, port_data_valid, tx_valid, rx_ready, irq);
        end
        bus_read(16'h1001, d, v);
        total++;
        if (d !== 16'h000A || v !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: got %h valid=%b, want 000a valid=1", d, v);
        end
    endtask

    task automatic test_tx_path();
        logic [15:0] d;
        logic        v;
        logic [15:0] exp_words [3];
        exp_words[0] = 16'hA001;
        exp_words[1] = 16'hA002;
        exp_words[2] = 16'hA003;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(16'h1000, exp_words[i]);
        bus_read(16'h1002, d, v);
        total++;
        if (d !== 16'h0003) begin
            bad++;
            $display("FAIL tx_level: got %h, want 0003", d);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp_words[i]) begin
                bad++;
                $display("FAIL tx_stream[%0d]: got valid=%b data=%h, want 1 %h", i, tx_valid, tx_data, exp_words[i]);
            end
            cyc();
        end
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL tx_drained: got tx_valid=%b, want 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 17; i++) bus_write(16'h1000, 16'hC000 + 16'(i));
        bus_read(16'h1001, d, v);
        total++;
        if (d !== 16'h0019 || irq !== 1'b1) begin
            bad++;
            $display("FAIL ovf_status: got %h irq=%b, want 0019 irq=1", d, irq);
        end
        bus_read(16'h1002, d, v);
        total++;
        if (d !== 16'h0010) begin
            bad++;
            $display("FAIL ovf_level: got %h, want 0010", d);
        end
        bus_write(16'h1001, 16'h0010);
        bus_read(16'h1001, d, v);
        total++;
        if (d !== 16'h0009 || irq !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %h irq=%b, want 0009 irq=0", d, irq);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (tx_data !== 16'hC000 + 16'(i)) begin
                bad++;
                $display("FAIL ovf_drain[%0d]: got %h, want %h", i, tx_data, 16'hC000 + 16'(i));
            end
            cyc();
        end
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_dropped: got tx_valid=%b, want 0", tx_valid);
        end
    endtask

    task automatic test_rx_path();
        logic [15:0] d;
        logic        v;
        rx_push(16'hBEEF);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL rx_irq: got %b, want 1", irq);
        end
        rx_push(16'h1234);
        bus_read(16'h1000, d, v);
        total++;
        if (d !== 16'hBEEF || v !== 1'b1) begin
            bad++;
            $display("FAIL rx_read0: got %h valid=%b, want beef 1", d, v);
        end
        bus_read(16'h1000, d, v);
        total++;
        if (d !== 16'h1234 || v !== 1'b1) begin
            bad++;
            $display("FAIL rx_read1: got %h valid=%b, want 1234 1", d, v);
        end
        bus_read(16'h1000, d, v);
        total++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            bad++;
            $display("FAIL rx_underflow_read: got %h valid=%b, want 0000 1", d, v);
        end
        cyc();
        total++;
        if (port_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse_width: got %b, want 0", port_data_valid);
        end
        bus_read(16'h1001, d, v);
        total++;
        if (d !== 16'h002A || irq !== 1'b1) begin
            bad++;
            $display("FAIL rx_underflow_status: got %h irq=%b, want 002a irq=1", d, irq);
        end
        bus_write(16'h1001, 16'h0020);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL udf_clear_irq: got %b, want 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic        v;
        logic [15:0] got [3];
        tx_ready     = 1'b1;
        port_address = 16'h1000;
        port_wr      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            port_data = 16'hD000 + 16'(i);
            cyc();
        end
        port_wr  = 1'b0;
        tx_ready = 1'b0;
        bus_read(16'h1002, d, v);
        total++;
        if (d !== 16'h0001 || tx_data !== 16'hD004) begin
            bad++;
            $display("FAIL pushpop_level: got level=%h head=%h, want 0001 d004", d, tx_data);
        end
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        rx_push(16'h0111);
        rx_push(16'h0222);
        rx_push(16'h0333);
        port_address = 16'h1000;
        port_rd      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            got[i] = port_data_out;
        end
        port_rd = 1'b0;
        total++;
        if (got[0] !== 16'h0111 || got[1] !== 16'h0222 || got[2] !== 16'h0333) begin
            bad++;
            $display("FAIL b2b_reads: got %h %h %h, want 0111 0222 0333", got[0], got[1], got[2]);
        end
        bus_read(16'h1007, d, v);
        total++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            bad++;
            $display("FAIL unmapped_read: got %h valid=%b, want 0000 1", d, v);
        end
        bus_read(16'h1003, d, v);
        bus_read(16'h2000, d, v);
        total++;
        if (v !== 1'b0 || d !== 16'h0000) begin
            bad++;
            $display("FAIL nonhit_read: got %h valid=%b, want 0000 0", d, v);
        end
        port_address = 16'h1000;
        port_data    = 16'hE0E0;
        port_wr      = 1'b1;
        port_rd      = 1'b1;
        cyc();
        port_wr      = 1'b0;
        port_rd      = 1'b0;
        total++;
        if (port_data_valid !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 16'hE0E0) begin
            bad++;
            $display("FAIL rdwr_both: got valid=%b txv=%b txd=%h, want 0 1 e0e0", port_data_valid, tx_valid, tx_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        v;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(16'h1000, 16'hF000 + 16'(i));
        for (int i = 0; i < 5; i++) rx_push(16'hF100 + 16'(i));
        port_address = 16'h1000;
        port_rd      = 1'b1;
        RST          = 1'b1;
        cyc();
        port_rd      = 1'b0;
        cyc();
        RST          = 1'b0;
        total++;
        if ({port_data_valid, tx_valid, rx_ready, irq} !== 4'b0010) begin
            bad++;
            $display("FAIL midrst_outputs: got valid=%b txv=%b rxr=%b irq=%b, want 0 0 1 0",
                     port_data_valid, tx_valid, rx_ready, irq);
        end
        bus_read(16'h1001, d, v);
        total++;
        if (d !== 16'h000A) begin
            bad++;
            $display("FAIL midrst_status: got %h, want 000a", d);
        end
        bus_read(16'h1003, d, v);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_rxlevel: got %h, want 0000", d);
        end
    endtask

    initial begin
        RST          = 1'b1;
        port_address = 16'h0000;
        port_data    = 16'h0000;
        port_rd      = 1'b0;
        port_wr      = 1'b0;
        tx_ready     = 1'b0;
        rx_data      = 16'h0000;
        rx_valid     = 1'b0;
        test_reset();
        test_tx_path();
        test_tx_overflow();
        test_rx_path();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_fifo_peripheral.md
# port_fifo_peripheral

Peripheral-side responder on the CPU I/O port bus. It decodes a 16-word port window and hosts two FIFOs. The TX FIFO is filled by CPU port writes and drained by a downstream valid/ready stream. The RX FIFO is filled by an upstream valid/ready stream and drained by CPU port reads. It connects directly to the registered port_address/port_data/port_rd/port_wr outputs of the CPU port stage and returns registered read data.

## Interface
- BITS, 16, port data and FIFO word width
- ADDRESS_BITS, 16, port address width
- BASE_ADDRESS, 16'h1000, window base; the low 4 bits are ignored
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries)
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- port_address  in  ADDRESS_BITS  port address from CPU port stage
- port_data  in  BITS  port write data
- port_rd  in  1  read strobe, one cycle per access
- port_wr  in  1  write strobe, one cycle per access
- port_data_out  out  BITS  registered read data
- port_data_valid  out  1  one-cycle pulse qualifying port_data_out
- tx_data  out  BITS  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  consumer accepts tx_data
- rx_data  in  BITS  producer word
- rx_valid  in  1  producer word valid
- rx_ready  out  1  RX FIFO not full
- irq  out  1  level interrupt: RX FIFO not empty, or any sticky error flag set

## Operation
- Hit condition: port_address[ADDRESS_BITS-1:4] == BASE_ADDRESS[ADDRESS_BITS-1:4].
- Offsets (port_address[3:0]):
  - 0: write pushes to TX FIFO; read pops RX FIFO.
  - 1: STATUS. Read-only bits: 0 tx_full, 1 tx_empty, 2 rx_full, 3 rx_empty. Sticky bits: 4 tx_overflow, 5 rx_underflow; writing 1 to either clears it.
  - 2: TX level, read-only.
  - 3: RX level, read-only.
  - 4–15: unmapped. Writes are ignored; reads return 0 with valid pulsed.
- Reads of read-only offsets have no side effect.
- Write to offset 0 while tx_full: word dropped, tx_overflow set.
- Read of offset 0 while rx_empty: returns 0, no pop, rx_underflow set.
- port_rd and port_wr both high: the write is performed, the read is ignored, and no valid pulse is generated.
- Non-hit accesses: no effect at all.
- Stream handshake: a transfer occurs on a cycle with valid & ready. tx_data is the FIFO head, combinational from storage.
- Full/empty are evaluated on start-of-cycle state:
  - A CPU write to a full TX FIFO is dropped even if tx_ready pops in the same cycle.
  - An rx push to a full RX FIFO is impossible because rx_ready=0.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: level unchanged.
- Levels are DEPTH_LOG2+1 bits, zero-extended to BITS. Pointers wrap modulo 2^DEPTH_LOG2.
- Reset values: port_data_out=0, port_data_valid=0, both FIFOs empty (tx_valid=0, rx_ready=1 from the cycle after RST deasserts), sticky flags 0, irq=0.
- RST mid-operation discards all FIFO contents and any in-flight read.

## Timing
- Port read: strobe in cycle N → port_data_out and port_data_valid in cycle N+1. port_data_out holds its value until the next read.
- A pop or status update caused by a read or write in cycle N is visible in state at N+1.
  - Back-to-back reads of offset 0 return consecutive RX words.
- TX write in cycle N → tx_valid high at N+1 if the FIFO was empty.
- RX push in cycle N → rx_empty clears and irq asserts at N+1. The word is readable by a port read issued at N+1.
- irq is combinational from registered state; it has no input-to-output combinational path.

## Structure
- Shared package holds the offset constants (OFF_DATA, OFF_STATUS, OFF_TXLVL, OFF_RXLVL) and the STATUS bit indices.
- One sub-module, port_fifo: synchronous single-clock FIFO with parameters BITS and DEPTH_LOG2. Ports: push, pop, din, dout (head), full, empty, level. It is instantiated twice.

## Test plan
- Reset: hold RST 2 cycles → all outputs at their reset values; STATUS reads 16'h000A.
- TX path: write 16'hA001, 16'hA002, 16'hA003 to 16'h1000 with tx_ready=0 → TX level 3. Then raise tx_ready → tx_data emits A001, A002, A003 on consecutive cycles; tx_valid drops after the third.
- TX overflow: 17 writes with tx_ready=0 → the 17th is dropped. STATUS = 16'h0019, irq=1. Write 16'h0010 to 16'h1001 → STATUS = 16'h0009, irq=0.
- RX path: push 16'hBEEF and 16'h1234 on the stream → irq=1. Two reads of 16'h1000 return BEEF then 1234, each one cycle after its strobe. A third read returns 0 and sets rx_underflow (STATUS bit 5).
- Simultaneous push/pop and unmapped access: hold tx_ready=1 while writing every cycle → level stays 1. A read of 16'h1007 returns 0 with a valid pulse. A read of 16'h2000 produces no valid pulse.
- Reset mid-operation: RST with 5 words queued in each FIFO → both FIFOs empty, flags clear, no stale port_data_valid pulse.
